// File: rtl/mem_wb_skid_reg.sv
// MEM->WB stage register with a 2-entry skid buffer and registered ready.
// Optional perf counters are enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_skid_reg #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    dw_in,
    input  logic [AW-1:0]    aw_in,
    input  logic             regwr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    dw_out,
    output logic [AW-1:0]    aw_out,
    output logic             regwr_out,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_drop_cnt
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          regwr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;
    entry_t mainQ;
    entry_t skidQ;
    entry_t inEntry;
    logic   inFire;
    logic   outFire;
    logic   loadMainIn;
    logic   loadMainSkid;
    logic   loadSkid;
    logic   clrRegwr;

    assign inEntry   = '{data: dw_in, addr: aw_in, regwr: regwr_in};
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign inFire    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready;
    assign occupancy = state;
    assign dw_out    = mainQ.data;
    assign aw_out    = mainQ.addr;
    assign regwr_out = mainQ.regwr & out_valid;

    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        clrRegwr     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (inFire) begin
                    loadMainIn = 1'b1;
                    stateNext  = ONE;
                end
            end
            ONE: begin
                if (inFire && outFire) begin
                    loadMainIn = 1'b1;
                end else if (inFire) begin
                    loadSkid  = 1'b1;
                    stateNext = TWO;
                end else if (outFire) begin
                    stateNext = EMPTY;
                end
            end
            TWO: begin
                if (outFire) begin
                    loadMainSkid = 1'b1;
                    stateNext    = ONE;
                end
            end
            default: stateNext = EMPTY;
        endcase
        // Flush accepts and discards whatever fired this cycle.
        if (flush) begin
            stateNext    = EMPTY;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
            loadSkid     = 1'b0;
            clrRegwr     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            state <= stateNext;
            if (loadMainIn) begin
                mainQ <= inEntry;
            end else if (loadMainSkid) begin
                mainQ <= skidQ;
            end else if (clrRegwr) begin
                mainQ.regwr <= 1'b0;
            end
            if (loadSkid) begin
                skidQ <= inEntry;
            end
        end
    end

`ifdef MEM_WB_PERF_CNT_EN
    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] stallQ;
    logic [CNT_W-1:0] dropQ;
    logic [CNT_W+1:0] dropSum;

    // Never negative: out_fire implies at least one entry was held.
    assign dropSum = {2'b00, dropQ}
                   + (CNT_W+2)'(state)
                   + (CNT_W+2)'(inFire)
                   - (CNT_W+2)'(outFire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallQ <= '0;
            dropQ  <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && stallQ != '1) begin
                stallQ <= stallQ + 1'b1;
            end
            if (flush) begin
                dropQ <= (dropSum > CNT_MAX) ? '1 : dropSum[CNT_W-1:0];
            end
        end
    end

    assign stall_cnt      = stallQ;
    assign flush_drop_cnt = dropQ;
`else
    assign stall_cnt      = '0;
    assign flush_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed self-checking bench for mem_wb_skid_reg.
// Counter checks follow MEM_WB_PERF_CNT_EN.
module tb_mem_wb_skid_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dw_in;
    logic [4:0]  aw_in;
    logic        regwr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dw_out;
    logic [4:0]  aw_out;
    logic        regwr_out;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic [15:0] flush_drop_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_dw_out;
    logic [4:0]  s_aw_out;
    logic        s_regwr_out;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_cnt;
    logic [2:0]  s_flush_drop_cnt;

    int nChecks = 0;
    int nFail   = 0;

    mem_wb_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .dw_in(dw_in), .aw_in(aw_in), .regwr_in(regwr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .dw_out(dw_out), .aw_out(aw_out), .regwr_out(regwr_out),
        .occupancy(occupancy), .stall_cnt(stall_cnt),
        .flush_drop_cnt(flush_drop_cnt)
    );

    mem_wb_skid_reg #(.CNT_W(3)) dutSmall (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .dw_in(dw_in), .aw_in(aw_in), .regwr_in(regwr_in),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .dw_out(s_dw_out), .aw_out(s_aw_out), .regwr_out(s_regwr_out),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt),
        .flush_drop_cnt(s_flush_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dw_in = '0; aw_in = '0; regwr_in = 1'b0;
        #3;
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            nFail++;
            $display("FAIL reset_flags: out_valid=%b in_ready=%b occ=%0d, want 0 1 0",
                     out_valid, in_ready, occupancy);
        end
        nChecks++;
        if (dw_out !== 32'h0 || aw_out !== 5'h0 || regwr_out !== 1'b0) begin
            nFail++;
            $display("FAIL reset_data: dw=%h aw=%h regwr=%b, want 0 0 0",
                     dw_out, aw_out, regwr_out);
        end
        nChecks++;
        if (stall_cnt !== 16'h0 || flush_drop_cnt !== 16'h0) begin
            nFail++;
            $display("FAIL reset_cnt: stall=%0d drop=%0d, want 0 0",
                     stall_cnt, flush_drop_cnt);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        logic [31:0] dv [3] = '{32'h11, 32'h22, 32'h33};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        regwr_in  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dw_in = dv[i];
            aw_in = 5'(i + 1);
            step();
            nChecks++;
            if (out_valid !== 1'b1 || dw_out !== dv[i] || aw_out !== 5'(i + 1) ||
                regwr_out !== 1'b1 || occupancy !== 2'd1) begin
                nFail++;
                $display("FAIL stream_%0d: v=%b dw=%h aw=%0d rw=%b occ=%0d, want 1 %h %0d 1 1",
                         i, out_valid, dw_out, aw_out, regwr_out, occupancy, dv[i], i + 1);
            end
        end
        in_valid = 1'b0;
        step();
        nChecks++;
        if (out_valid !== 1'b0 || regwr_out !== 1'b0 || occupancy !== 2'd0) begin
            nFail++;
            $display("FAIL stream_drain: v=%b rw=%b occ=%0d, want 0 0 0",
                     out_valid, regwr_out, occupancy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        regwr_in  = 1'b1;
        dw_in = 32'hA0; aw_in = 5'd4;
        step();
        dw_in = 32'hB0; aw_in = 5'd5;
        step();
        nChecks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || dw_out !== 32'hA0 ||
            aw_out !== 5'd4) begin
            nFail++;
            $display("FAIL bp_full: occ=%0d rdy=%b dw=%h aw=%0d, want 2 0 a0 4",
                     occupancy, in_ready, dw_out, aw_out);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        nChecks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || dw_out !== 32'hB0 ||
            aw_out !== 5'd5 || out_valid !== 1'b1) begin
            nFail++;
            $display("FAIL bp_pop1: occ=%0d rdy=%b dw=%h aw=%0d v=%b, want 1 1 b0 5 1",
                     occupancy, in_ready, dw_out, aw_out, out_valid);
        end
        step();
        nChecks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            nFail++;
            $display("FAIL bp_pop2: occ=%0d v=%b, want 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        regwr_in  = 1'b0;
        dw_in = 32'h5; aw_in = 5'd7;
        step();
        dw_in = 32'h6; aw_in = 5'd8; regwr_in = 1'b1;
        out_ready = 1'b1;
        step();
        nChecks++;
        if (occupancy !== 2'd1 || dw_out !== 32'h6 || aw_out !== 5'd8 ||
            regwr_out !== 1'b1) begin
            nFail++;
            $display("FAIL simul: occ=%0d dw=%h aw=%0d rw=%b, want 1 6 8 1",
                     occupancy, dw_out, aw_out, regwr_out);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        logic [15:0] expDrop;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        regwr_in  = 1'b1;
        dw_in = 32'h1; aw_in = 5'd1;
        step();
        dw_in = 32'h2; aw_in = 5'd2;
        step();
        dw_in = 32'h3; aw_in = 5'd3;
        flush = 1'b1;
        step();
        flush = 1'b0;
        nChecks++;
        if (occupancy !== 2'd0 || regwr_out !== 1'b0 || out_valid !== 1'b0 ||
            in_ready !== 1'b1) begin
            nFail++;
            $display("FAIL flush_two: occ=%0d rw=%b v=%b rdy=%b, want 0 0 0 1",
                     occupancy, regwr_out, out_valid, in_ready);
        end
`ifdef MEM_WB_PERF_CNT_EN
        expDrop = 16'd2;
`else
        expDrop = 16'd0;
`endif
        nChecks++;
        if (flush_drop_cnt !== expDrop) begin
            nFail++;
            $display("FAIL flush_cnt2: drop=%0d, want %0d", flush_drop_cnt, expDrop);
        end
        dw_in = 32'h7; aw_in = 5'd9;
        step();
        nChecks++;
        if (occupancy !== 2'd1 || dw_out !== 32'h7 || regwr_out !== 1'b1) begin
            nFail++;
            $display("FAIL flush_after: occ=%0d dw=%h rw=%b, want 1 7 1",
                     occupancy, dw_out, regwr_out);
        end
        // ONE state: in_fire and out_fire together with flush -> 1+1-1 dropped
        dw_in = 32'h8;
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
`ifdef MEM_WB_PERF_CNT_EN
        expDrop = 16'd3;
`endif
        nChecks++;
        if (occupancy !== 2'd0 || flush_drop_cnt !== expDrop) begin
            nFail++;
            $display("FAIL flush_one: occ=%0d drop=%0d, want 0 %0d",
                     occupancy, flush_drop_cnt, expDrop);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        regwr_in  = 1'b1;
        dw_in = 32'hC1; aw_in = 5'd11;
        step();
        dw_in = 32'hC2; aw_in = 5'd12;
        step();
        in_valid = 1'b0;
        nChecks++;
        if (occupancy !== 2'd2) begin
            nFail++;
            $display("FAIL areset_pre: occ=%0d, want 2", occupancy);
        end
        #2;
        reset = 1'b0;
        #1;
        nChecks++;
        if (out_valid !== 1'b0 || regwr_out !== 1'b0 || dw_out !== 32'h0 ||
            occupancy !== 2'd0 || in_ready !== 1'b1) begin
            nFail++;
            $display("FAIL areset: v=%b rw=%b dw=%h occ=%0d rdy=%b, want 0 0 0 0 1",
                     out_valid, regwr_out, dw_out, occupancy, in_ready);
        end
        step();
        reset = 1'b1;
        step();
        nChecks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            nFail++;
            $display("FAIL areset_post: v=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_counters();
        logic [15:0] exp7;
        logic [15:0] exp9;
        logic [2:0]  expSat;
`ifdef MEM_WB_PERF_CNT_EN
        exp7 = 16'd7; exp9 = 16'd9; expSat = 3'd7;
`else
        exp7 = 16'd0; exp9 = 16'd0; expSat = 3'd0;
`endif
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dw_in = 32'hD0; aw_in = 5'd1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        nChecks++;
        if (stall_cnt !== exp7) begin
            nFail++;
            $display("FAIL stall_7: cnt=%0d, want %0d", stall_cnt, exp7);
        end
        repeat (2) step();
        nChecks++;
        if (stall_cnt !== exp9 || s_stall_cnt !== expSat) begin
            nFail++;
            $display("FAIL stall_sat: cnt=%0d small=%0d, want %0d %0d",
                     stall_cnt, s_stall_cnt, exp9, expSat);
        end
        nChecks++;
        if (s_out_valid !== 1'b1 || s_dw_out !== 32'hD0) begin
            nFail++;
            $display("FAIL small_head: v=%b dw=%h, want 1 d0", s_out_valid, s_dw_out);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
